// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Sits between the MEM stage and port 2 of the shared quad-word memory.
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   cpu_read/cpu_write       word request (write wins if both), held until cpu_done
//   cpu_addr/cpu_wdata       word address / write data
//   cpu_rdata/cpu_done       read data / one-cycle completion pulse
//   mem_read/mem_write_q     line read / line write request, dropped while mem_ack
//   mem_addr/mem_wdata       line-aligned address / line write data (word n at [16n+15:16n])
//   mem_rdata/mem_ack        line read data / memory completion pulse
//   hit_count/miss_count     wrapping performance counters
module dcache_ctrl #(
  parameter int unsigned LINES     = 4,
  parameter int unsigned WORD_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cpu_read,
  input  logic                   cpu_write,
  input  logic [15:0]            cpu_addr,
  input  logic [WORD_SIZE-1:0]   cpu_wdata,
  output logic [WORD_SIZE-1:0]   cpu_rdata,
  output logic                   cpu_done,
  output logic                   mem_read,
  output logic                   mem_write_q,
  output logic [15:0]            mem_addr,
  output logic [4*WORD_SIZE-1:0] mem_wdata,
  input  logic [4*WORD_SIZE-1:0] mem_rdata,
  input  logic                   mem_ack,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
);

  localparam int unsigned IDX = $clog2(LINES);
  localparam int unsigned TW  = 14 - IDX;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_t;
  typedef logic [3:0][WORD_SIZE-1:0] line_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q, dirty_q;
  logic [TW-1:0]    tag_q  [LINES];
  line_t            data_q [LINES];
  line_t            fill_q, fill_merged;

  logic [15:0]           req_addr_q;
  logic [WORD_SIZE-1:0]  req_wdata_q;
  logic                  req_wr_q;
  logic [WORD_SIZE-1:0]  rdata_q;
  logic [15:0]           hit_q, miss_q;

  // Incoming request decode (IDLE) and latched request decode (WB/FILL).
  logic [IDX-1:0] in_idx, r_idx;
  logic [TW-1:0]  in_tag, r_tag;
  logic [1:0]     in_off, r_off;
  logic           req, hit;

  assign in_off = cpu_addr[1:0];
  assign in_idx = cpu_addr[IDX+1:2];
  assign in_tag = cpu_addr[15:IDX+2];
  assign r_off  = req_addr_q[1:0];
  assign r_idx  = req_addr_q[IDX+1:2];
  assign r_tag  = req_addr_q[15:IDX+2];
  assign req    = cpu_read | cpu_write;
  assign hit    = valid_q[in_idx] && (tag_q[in_idx] == in_tag);

  always_comb begin
    fill_merged = fill_q;
    if (req_wr_q) fill_merged[r_off] = req_wdata_q;
  end

  // Next state and memory-side outputs; requests fall in the ack cycle.
  always_comb begin
    state_d     = state_q;
    mem_read    = 1'b0;
    mem_write_q = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    cpu_done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit)                                  state_d = S_DONE;
          else if (valid_q[in_idx] && dirty_q[in_idx]) state_d = S_WB;
          else                                      state_d = S_FILL;
        end
      end
      S_WB: begin
        mem_write_q = !mem_ack;
        mem_addr    = {tag_q[r_idx], r_idx, 2'b00};
        mem_wdata   = data_q[r_idx];
        if (mem_ack) state_d = S_FILL;
      end
      S_FILL: begin
        mem_read = !mem_ack;
        mem_addr = {r_tag, r_idx, 2'b00};
        if (mem_ack) state_d = S_DONE;
      end
      S_DONE: begin
        cpu_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: reset clears valid/dirty so an interrupted fill stays invalid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      rdata_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req) begin
        if (hit) begin
          hit_q <= hit_q + 16'd1;
          if (cpu_write) dirty_q[in_idx] <= 1'b1;
          else           rdata_q <= data_q[in_idx][in_off];
        end else begin
          miss_q <= miss_q + 16'd1;
        end
      end
      if (state_q == S_WB && mem_ack) dirty_q[r_idx] <= 1'b0;
      if (state_q == S_FILL && mem_ack) begin
        valid_q[r_idx] <= 1'b1;
        dirty_q[r_idx] <= req_wr_q;
        if (!req_wr_q) rdata_q <= fill_q[r_off];
      end
    end
  end

  // Line storage and request capture need no reset.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state_q == S_IDLE && req) begin
        req_addr_q  <= cpu_addr;
        req_wdata_q <= cpu_wdata;
        req_wr_q    <= cpu_write;
        if (hit && cpu_write) data_q[in_idx][in_off] <= cpu_wdata;
      end
      if (mem_read) fill_q <= mem_rdata;
      if (state_q == S_FILL && mem_ack) begin
        tag_q[r_idx]  <= r_tag;
        data_q[r_idx] <= fill_merged;
      end
    end
  end

  assign cpu_rdata  = rdata_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_done, mem_read, mem_write_q;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] hit_count, miss_count;

  dcache_ctrl #(.LINES(4), .WORD_SIZE(16)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_done(cpu_done), .mem_read(mem_read), .mem_write_q(mem_write_q),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Backing memory (what port 2 holds) and CPU-visible memory (latest writes).
  logic [15:0] bmem    [65536];
  logic [15:0] ref_mem [65536];
  // Which line each index holds, per the direct-mapped placement rule.
  bit          mv [4];
  bit          md [4];
  logic [11:0] mt [4];
  int          nh, nm;

  // Port-2 memory: 6 busy cycles, ack on the 7th cycle of a held request.
  int mcnt = 0;
  always begin
    @(posedge clk);
    #1;
    if (mem_ack) begin mem_ack = 1'b0; mcnt = 0; end
    #1;
    if (mem_read || mem_write_q) begin
      mcnt++;
      mem_rdata = {bmem[int'(mem_addr)+3], bmem[int'(mem_addr)+2],
                   bmem[int'(mem_addr)+1], bmem[int'(mem_addr)]};
      if (mcnt == 7) begin
        if (mem_write_q)
          for (int w = 0; w < 4; w++) bmem[int'(mem_addr)+w] = mem_wdata[16*w +: 16];
        mem_ack = 1'b1;
      end
    end else begin
      mcnt = 0;
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      // Dirty data held only in the cache is lost on reset.
      if (mv[i] && md[i])
        for (int w = 0; w < 4; w++) ref_mem[{mt[i], 2'(i), 2'(w)}] = bmem[{mt[i], 2'(i), 2'(w)}];
      mv[i] = 0; md[i] = 0; mt[i] = '0;
    end
    nh = 0; nm = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic access(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                        output logic [15:0] rdata_o, output int lat_o, output logic [63:0] wbd_o);
    int          idx, cyc, exp_lat;
    logic [11:0] tg;
    bit          hit, dev, got, saw_wb, saw_rd;
    logic [15:0] vbase, wb_addr, rd_addr;
    logic [63:0] vdata;
    idx   = int'(a[3:2]);
    tg    = a[15:4];
    hit   = mv[idx] && (mt[idx] == tg);
    dev   = !hit && mv[idx] && md[idx];
    vbase = {mt[idx], a[3:2], 2'b00};
    vdata = {ref_mem[vbase+3], ref_mem[vbase+2], ref_mem[vbase+1], ref_mem[vbase]};
    exp_lat = hit ? 1 : (dev ? 15 : 8);
    @(negedge clk);
    cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = wd;
    cyc = 0; got = 0; saw_wb = 0; saw_rd = 0;
    wb_addr = '0; rd_addr = '0; wbd_o = '0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      chk("req_exclusive", {63'd0, mem_read & mem_write_q}, 64'd0);
      if (mem_write_q && !saw_wb) begin saw_wb = 1; wb_addr = mem_addr; wbd_o = mem_wdata; end
      if (mem_read && !saw_rd) begin saw_rd = 1; rd_addr = mem_addr; end
      if (cpu_done) got = 1;
    end
    rdata_o = cpu_rdata;
    lat_o   = cyc;
    cpu_read = 1'b0; cpu_write = 1'b0;
    if (hit) nh++; else nm++;
    chk("latency", 64'(cyc), 64'(exp_lat));
    if (!wr) chk("rdata", {48'd0, cpu_rdata}, {48'd0, ref_mem[a]});
    chk("hit_count", {48'd0, hit_count}, 64'(nh[15:0]));
    chk("miss_count", {48'd0, miss_count}, 64'(nm[15:0]));
    chk("fill_issued", {63'd0, saw_rd}, {63'd0, !hit});
    if (!hit) chk("fill_addr", {48'd0, rd_addr}, {48'd0, tg, a[3:2], 2'b00});
    chk("wb_issued", {63'd0, saw_wb}, {63'd0, dev});
    if (dev) begin
      chk("wb_addr", {48'd0, wb_addr}, {48'd0, vbase});
      chk("wb_data", wbd_o, vdata);
    end
    if (!hit) begin mv[idx] = 1; mt[idx] = tg; md[idx] = 0; end
    if (wr) begin md[idx] = 1; ref_mem[a] = wd; end
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] exp_rd;
    int          exp_lat;
    logic [63:0] exp_wb;
    logic [63:0] wb_mask;
  } vec_t;

  vec_t vt[11];

  initial begin
    logic [15:0] rdv;
    int          lat;
    logic [63:0] wbd;
    int          cyc;

    vt[0]  = '{1, 0, 16'h0024, 16'h0000, 16'hf01c, 8,  64'h0, 64'h0};
    vt[1]  = '{1, 0, 16'h0025, 16'h0000, 16'h6100, 1,  64'h0, 64'h0};
    vt[2]  = '{0, 1, 16'h0026, 16'hbeef, 16'h0000, 1,  64'h0, 64'h0};
    vt[3]  = '{1, 0, 16'h0034, 16'h0000, 16'hf41c, 15, 64'h6200_beef_6100_f01c, '1};
    vt[4]  = '{0, 1, 16'h0040, 16'h1234, 16'h0000, 8,  64'h0, 64'h0};
    vt[5]  = '{1, 0, 16'h0040, 16'h0000, 16'h1234, 1,  64'h0, 64'h0};
    vt[6]  = '{1, 0, 16'h0041, 16'h0000, 16'hf9c1, 1,  64'h0, 64'h0};
    vt[7]  = '{1, 0, 16'h0080, 16'h0000, 16'h0a80, 15, 64'h1234, 64'hffff};
    vt[8]  = '{1, 1, 16'h0081, 16'h5a5a, 16'h0000, 1,  64'h0, 64'h0};
    vt[9]  = '{1, 0, 16'h00c0, 16'h0000, 16'h0cc0, 15, 64'h5a5a_0000, 64'hffff_0000};
    vt[10] = '{1, 0, 16'h0081, 16'h0000, 16'h5a5a, 8,  64'h0, 64'h0};

    for (int i = 0; i < 65536; i++) begin
      bmem[i] = 16'((i * 40503 + 7) ^ (i >> 3));
    end
    bmem[16'h0024] = 16'hf01c; bmem[16'h0025] = 16'h6100;
    bmem[16'h0026] = 16'h6300; bmem[16'h0027] = 16'h6200;
    bmem[16'h0034] = 16'hf41c; bmem[16'h0041] = 16'hf9c1;
    bmem[16'h0080] = 16'h0a80; bmem[16'h00c0] = 16'h0cc0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = bmem[i];
    for (int i = 0; i < 4; i++) begin mv[i] = 0; md[i] = 0; mt[i] = '0; end
    nh = 0; nm = 0;

    // Reset state.
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_done", {63'd0, cpu_done}, 64'd0);
    chk("rst_rdata", {48'd0, cpu_rdata}, 64'd0);
    chk("rst_mem_read", {63'd0, mem_read}, 64'd0);
    chk("rst_mem_write", {63'd0, mem_write_q}, 64'd0);
    chk("rst_mem_addr", {48'd0, mem_addr}, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_hits", {48'd0, hit_count}, 64'd0);
    chk("rst_misses", {48'd0, miss_count}, 64'd0);

    // Directed vectors.
    for (int i = 0; i < 11; i++) begin
      access(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd, rdv, lat, wbd);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].exp_lat));
      if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), {48'd0, rdv}, {48'd0, vt[i].exp_rd});
      if (vt[i].wb_mask != 0)
        chk($sformatf("vec%0d_wbdata", i), wbd & vt[i].wb_mask, vt[i].exp_wb);
    end

    // Reset during FILL cycle 3 aborts the fill and clears the counters.
    do_reset();
    @(negedge clk);
    cpu_read = 1'b1; cpu_addr = 16'h0024;
    cyc = 0;
    while (cyc < 3) begin @(negedge clk); cyc++; end
    chk("abort_fill_active", {63'd0, mem_read}, 64'd1);
    reset_n = 1'b0; cpu_read = 1'b0;
    @(negedge clk);
    chk("abort_mem_read", {63'd0, mem_read}, 64'd0);
    chk("abort_mem_write", {63'd0, mem_write_q}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    access(1, 0, 16'h0024, 16'h0, rdv, lat, wbd);
    chk("abort_reread_lat", 64'(lat), 64'd8);
    chk("abort_reread_misses", {48'd0, miss_count}, 64'd1);
    chk("abort_reread_hits", {48'd0, hit_count}, 64'd0);

    // Randomized traffic over a small address window to force hits and evictions.
    for (int n = 0; n < 300; n++) begin
      int unsigned kind;
      logic [15:0] a;
      kind = $urandom_range(0, 2);
      a = 16'($urandom_range(0, 127));
      access(kind != 1, kind != 0, a, 16'($urandom), rdv, lat, wbd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
